sb_spram256ka: RTL and testbench
================================

Name: sb_spram256ka

Overview:
Behavioural model of the iCE40UP 256 Kbit single-port SRAM: 16384 words x 16 bits, with nibble write masks and low-power modes. Two instances side by side form the 32-bit, 64 KB scratch RAM banks of the control SoC. Reads are synchronous with one-cycle latency. Writes are synchronous and nibble-masked.

Parameters:
None. The geometry is fixed at 14-bit address and 16-bit data.

Ports:
clk  input  1  rising-edge clock for all accesses
resetn  input  1  asynchronous active-low reset; clears the output register only, never the array
ADDRESS  input  14  word address
DATAIN  input  16  write data
MASKWREN  input  4  nibble write enables; bit i enables DATAIN[4i+3:4i]
WREN  input  1  1 = write cycle, 0 = read cycle
CHIPSELECT  input  1  access enable
STANDBY  input  1  1 = accesses ignored, contents and output held
SLEEP  input  1  1 = output forced to 0, contents retained
POWEROFF  input  1  active-low power switch; 0 = powered down, contents lost
DATAOUT  output  16  registered read data

Behaviour:
- Reset: resetn low asynchronously sets DATAOUT = 16'h0000. Array contents and per-word valid bits are untouched. Operation resumes at the first clk edge after resetn rises.
- Mode priority, evaluated at each rising clk edge:
  - POWEROFF=0: DATAOUT <= 0. All per-word valid bits are cleared. No access takes place.
  - SLEEP=1: DATAOUT <= 0. No access takes place. Contents are retained.
  - STANDBY=1: no access takes place. DATAOUT holds.
  - CHIPSELECT=0: no access takes place. DATAOUT holds.
  - Otherwise an active access is performed, as below.
- Active read (WREN=0): DATAOUT <= mem[ADDRESS] at that edge, so data is visible in the cycle after CHIPSELECT is sampled (1-cycle latency). A word whose valid bit is clear reads as 16'h0000.
- Active write (WREN=1):
  - For each i with MASKWREN[i]=1: mem[ADDRESS][4i+3:4i] <= DATAIN[4i+3:4i].
  - Unmasked nibbles keep their old value. For an invalid word, unmasked nibbles become 0.
  - The word's valid bit is set.
  - DATAOUT holds its previous value; there is no write-through.
- WREN=1 with MASKWREN=4'b0000: the array does not change, the valid bit is unchanged and DATAOUT holds.
- Back-to-back accesses are allowed every cycle.
  - A read following a write to the same address on the next edge returns the newly written data.
  - A write and a read cannot coincide, because the port is single-port.
- ADDRESS covers the full 0..16383 range. There are no out-of-range accesses and no wrap logic.
- Power-up: the array starts with all valid bits clear, so every word reads 0 until written.
- Leaving a low-power mode: the first active access may occur on the very next edge after SLEEP/STANDBY drop or POWEROFF rises. No wake-up delay is modelled.
- Inputs are sampled only at the rising clk edge. resetn is the only asynchronous input.
- X/Z on control inputs during an active edge is treated as no access, and DATAOUT holds.

Test Plan:
- Full write then read: CS=1, WREN=1, MASKWREN=1111, ADDRESS=5, DATAIN=16'h1234; next cycle WREN=0 → on the following cycle DATAOUT=16'h1234.
- Masked write: at address 5 (already 16'h1234), MASKWREN=0011, DATAIN=16'hABCD, then read → DATAOUT=16'h12CD. Repeat with MASKWREN=1000, DATAIN=16'h9000 → 16'h92CD.
- Hold cases: CS=0 with ADDRESS=7 → DATAOUT unchanged. STANDBY=1 with CS=1, WREN=1 → a subsequent read shows no write occurred. A write cycle leaves DATAOUT at the prior read value.
- Sleep and power-off:
  - Write 16'hBEEF at address 3, then assert SLEEP → DATAOUT=0; drop SLEEP, read 3 → 16'hBEEF.
  - Pulse POWEROFF=0 for one cycle, read 3 → 16'h0000.
  - Read of a never-written address 100 → 16'h0000.
- Async reset: with DATAOUT=16'h1234, assert resetn=0 mid-cycle → DATAOUT=0 immediately, with no clock edge required. Release resetn and read 5 → 16'h92CD (contents retained).
- Boundary addresses: write 16'hA5A5 at 0 and 16'h5A5A at 16383, read both → exact values. Neither write disturbs the other.

Source files
------------

// File: rtl/sb_spram256ka_if.sv
// Access port of the 16K x 16 single-port SRAM model.
// The master drives the address, data and mode pins. The slave returns registered read data.
interface sb_spram256ka_if;
  logic [13:0] ADDRESS;
  logic [15:0] DATAIN;
  logic [3:0]  MASKWREN;
  logic        WREN;
  logic        CHIPSELECT;
  logic        STANDBY;
  logic        SLEEP;
  logic        POWEROFF;
  logic [15:0] DATAOUT;

  modport master (
    output ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    input  DATAOUT
  );

  modport slave (
    input  ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    output DATAOUT
  );
endinterface

// File: rtl/sb_spram256ka.sv
// Behavioural iCE40UP SPRAM: 16384 x 16 storage, nibble-masked writes, one-cycle read latency.
// SLEEP and POWEROFF provide low-power modes. Each word has a valid bit so that lost contents read back as zero.
module sb_spram256ka (
  input  logic               clk,
  input  logic               resetn,
  sb_spram256ka_if.slave     bus
);

  logic [15:0]    mem_q [16384];
  logic [16383:0] valid_q, valid_d;
  logic [15:0]    dataout_q, dataout_d;

  logic        run;
  logic        pwr_off;
  logic        sleep_mode;
  logic        active;
  logic        mask_known;
  logic        do_read;
  logic        do_write;
  logic [15:0] bit_mask;
  logic [15:0] rd_word;
  logic [15:0] wr_word;

  // Controls are compared with === so that an X or Z on a pin falls through to "no access".
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    run        = (resetn === 1'b1);
    pwr_off    = run && (bus.POWEROFF === 1'b0);
    sleep_mode = run && (bus.POWEROFF === 1'b1) && (bus.SLEEP === 1'b1);
    active     = run && (bus.POWEROFF === 1'b1) && (bus.SLEEP === 1'b0) &&
                 (bus.STANDBY === 1'b0) && (bus.CHIPSELECT === 1'b1);
    mask_known = ((^bus.MASKWREN) !== 1'bx);
    do_read    = active && (bus.WREN === 1'b0);
    do_write   = active && (bus.WREN === 1'b1) && mask_known && (bus.MASKWREN != 4'b0000);

    bit_mask = {{4{bus.MASKWREN[3]}}, {4{bus.MASKWREN[2]}},
                {4{bus.MASKWREN[1]}}, {4{bus.MASKWREN[0]}}};

    // An invalid word contributes zeros, so its unmasked nibbles are cleared by a partial write.
    rd_word = valid_q[bus.ADDRESS] ? mem_q[bus.ADDRESS] : 16'h0000;
    wr_word = (rd_word & ~bit_mask) | (bus.DATAIN & bit_mask);

    dataout_d = dataout_q;
    if (pwr_off || sleep_mode) begin
      dataout_d = 16'h0000;
    end else if (do_read) begin
      dataout_d = rd_word;
    end

    // NOTE: blocking assignments here build the next-state values. The flops below take them with <=.
    valid_d = valid_q;
    if (pwr_off) begin
      valid_d = '0;
    end else if (do_write) begin
      valid_d[bus.ADDRESS] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dataout_q <= 16'h0000;
    end else begin
      dataout_q <= dataout_d;
    end
  end

  // NOTE: the array and its valid bits have no reset. The reset pin clears only the output register.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    if (do_write) begin
      mem_q[bus.ADDRESS] <= wr_word;
    end
  end

  assign bus.DATAOUT = dataout_q;

endmodule

// File: tb/tb_sb_spram256ka.sv
// Directed bench for sb_spram256ka.
// Read expectations are queued when a read is issued and compared once the registered data appears.
module tb_sb_spram256ka;

  typedef struct {
    string       tag;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  sb_spram256ka_if bus ();

  sb_spram256ka dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Outputs are sampled 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.CHIPSELECT = 1'b0;
    bus.WREN       = 1'b0;
    bus.MASKWREN   = 4'b0000;
  endtask

  task automatic wr(input logic [13:0] addr, input logic [15:0] data, input logic [3:0] mask);
    bus.ADDRESS    = addr;
    bus.DATAIN     = data;
    bus.MASKWREN   = mask;
    bus.WREN       = 1'b1;
    bus.CHIPSELECT = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd(input logic [13:0] addr, input logic [15:0] exp, input string tag);
    exp_t e;
    bus.ADDRESS    = addr;
    bus.WREN       = 1'b0;
    bus.CHIPSELECT = 1'b1;
    exp_q.push_back('{tag: tag, data: exp});
    tick();
    idle();
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 16'h0001, 16'h0000);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, bus.DATAOUT, e.data);
    end
  endtask

  initial begin
    resetn         = 1'b0;
    bus.ADDRESS    = '0;
    bus.DATAIN     = '0;
    bus.MASKWREN   = '0;
    bus.WREN       = 1'b0;
    bus.CHIPSELECT = 1'b0;
    bus.STANDBY    = 1'b0;
    bus.SLEEP      = 1'b0;
    bus.POWEROFF   = 1'b0;
    tick();
    tick();
    check("reset_dataout", bus.DATAOUT, 16'h0000);

    // Power-up sequence: one edge powered off clears every valid bit.
    resetn = 1'b1;
    tick();
    bus.POWEROFF = 1'b1;

    // Full write, then a read on the very next edge.
    wr(14'd5, 16'h1234, 4'b1111);
    rd(14'd5, 16'h1234, "full_wr_rd");

    // Nibble-masked writes.
    wr(14'd5, 16'hABCD, 4'b0011);
    rd(14'd5, 16'h12CD, "mask_0011");
    wr(14'd5, 16'h9000, 4'b1000);
    rd(14'd5, 16'h92CD, "mask_1000");

    // Hold cases.
    bus.ADDRESS    = 14'd7;
    bus.CHIPSELECT = 1'b0;
    tick();
    check("cs0_hold", bus.DATAOUT, 16'h92CD);

    bus.STANDBY    = 1'b1;
    bus.CHIPSELECT = 1'b1;
    bus.WREN       = 1'b1;
    bus.ADDRESS    = 14'd5;
    bus.DATAIN     = 16'hFFFF;
    bus.MASKWREN   = 4'b1111;
    tick();
    idle();
    bus.STANDBY = 1'b0;
    check("standby_hold", bus.DATAOUT, 16'h92CD);
    rd(14'd5, 16'h92CD, "standby_no_write");

    wr(14'd6, 16'h1111, 4'b1111);
    check("write_no_through", bus.DATAOUT, 16'h92CD);
    rd(14'd6, 16'h1111, "rd_addr6");

    wr(14'd5, 16'hFFFF, 4'b0000);
    rd(14'd5, 16'h92CD, "mask0_no_change");
    wr(14'd200, 16'hFFFF, 4'b0000);
    rd(14'd200, 16'h0000, "mask0_stays_invalid");
    wr(14'd300, 16'hABCD, 4'b0010);
    rd(14'd300, 16'h00C0, "invalid_partial_wr");

    // Asynchronous reset clears the output only.
    wr(14'd8, 16'h1234, 4'b1111);
    rd(14'd8, 16'h1234, "pre_reset_rd");
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset", bus.DATAOUT, 16'h0000);
    @(negedge clk);
    resetn = 1'b1;
    rd(14'd5, 16'h92CD, "contents_after_reset");

    // Sleep retains the array and forces the output to zero.
    wr(14'd3, 16'hBEEF, 4'b1111);
    rd(14'd3, 16'hBEEF, "rd_beef");
    bus.SLEEP = 1'b1;
    tick();
    check("sleep_zero", bus.DATAOUT, 16'h0000);
    bus.SLEEP = 1'b0;
    rd(14'd3, 16'hBEEF, "after_sleep");

    // Boundary addresses.
    wr(14'd0,     16'hA5A5, 4'b1111);
    wr(14'd16383, 16'h5A5A, 4'b1111);
    rd(14'd0,     16'hA5A5, "addr_min");
    rd(14'd16383, 16'h5A5A, "addr_max");

    // Power-off loses the contents.
    bus.POWEROFF = 1'b0;
    tick();
    check("poweroff_zero", bus.DATAOUT, 16'h0000);
    bus.POWEROFF = 1'b1;
    rd(14'd3,     16'h0000, "after_poweroff");
    rd(14'd16383, 16'h0000, "max_after_poweroff");
    rd(14'd100,   16'h0000, "never_written");

    check("scoreboard_empty", 16'(exp_q.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
